// File: rtl/dram_burst_xfer.sv
// DDR data-path burst engine: serialises a cache-line write onto DQ/DQS/DM_n
// with preamble/postamble, and captures a read burst on DQS edges into a line
// register with an idle timeout. BL8 / BC4 per command, sequential column wrap.
module dram_burst_xfer #(
  parameter int DQ_W      = 32,
  parameter int BURST_MAX = 8,
  parameter int PRE_CYC   = 1,
  parameter int RD_TO     = 16
) (
  input  logic                              CLKx2,
  input  logic                              nRST,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_wr,
  input  logic                              cmd_bc4,
  input  logic [$clog2(BURST_MAX)-1:0]      cmd_col,
  input  logic [BURST_MAX*DQ_W-1:0]         wdata,
  input  logic [BURST_MAX*(DQ_W/8)-1:0]     wmask,
  input  logic                              abort,
  output logic                              busy,
  output logic                              wdone,
  output logic                              rvalid,
  output logic                              rd_timeout,
  output logic [BURST_MAX*DQ_W-1:0]         rdata,
  output logic [DQ_W-1:0]                   rword,
  inout  wire  [DQ_W-1:0]                   DQ,
  inout  wire  [DQ_W/8-1:0]                 DQS_t,
  inout  wire  [DQ_W/8-1:0]                 DQS_c,
  inout  wire  [DQ_W/8-1:0]                 DM_n
);
  localparam int DQS_W = DQ_W / 8;
  localparam int CW    = $clog2(BURST_MAX);
  localparam int HW    = $clog2(BURST_MAX / 2);
  localparam int TW    = $clog2(RD_TO);
  localparam int PW    = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, WPRE, WDATA, WPST, RWAIT, RDATA} state_t;

  state_t                             state;
  logic [BURST_MAX-1:0][DQ_W-1:0]     wline_q;
  logic [BURST_MAX-1:0][DQS_W-1:0]    wmask_q;
  logic [BURST_MAX-1:0][DQ_W-1:0]     rline_q;
  logic [CW-1:0]                      l_col;
  logic                               l_bc4;
  logic [CW-1:0]                      beat;
  logic [PW-1:0]                      pre_cnt;
  logic [TW-1:0]                      to_cnt;
  logic                               s_dqs;
  logic                               oe;
  logic [DQ_W-1:0]                    dq_q;
  logic [DQS_W-1:0]                   dm_q;
  logic                               dqs_q;
  logic [CW-1:0]                      bl_m1;
  logic                               dqs_edge;

  // Word addressed by beat k: BC4 stays inside the aligned half-line,
  // BL8 wraps around the whole line through natural counter overflow.
  function automatic logic [CW-1:0] beat_idx(input logic [CW-1:0] col,
                                             input logic bc4,
                                             input logic [CW-1:0] k);
    logic [CW-1:0] base;
    base = col;
    if (bc4) base[HW-1:0] = '0;
    return base + k;
  endfunction

  assign bl_m1     = l_bc4 ? CW'(BURST_MAX/2 - 1) : CW'(BURST_MAX - 1);
  assign dqs_edge  = DQS_t[0] ^ s_dqs;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rdata     = rline_q;

  // Pins are driven only while a write burst owns the bus.
  assign DQ    = oe ? dq_q              : {DQ_W{1'bz}};
  assign DQS_t = oe ? {DQS_W{dqs_q}}    : {DQS_W{1'bz}};
  assign DQS_c = oe ? {DQS_W{~dqs_q}}   : {DQS_W{1'bz}};
  assign DM_n  = oe ? dm_q              : {DQS_W{1'bz}};

  // Burst FSM; pin values for the next cycle are computed one step ahead so
  // everything leaving the block comes straight from a flop.
  always_ff @(posedge CLKx2 or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      wline_q    <= '0;
      wmask_q    <= '0;
      rline_q    <= '0;
      rword      <= '0;
      l_col      <= '0;
      l_bc4      <= 1'b0;
      beat       <= '0;
      pre_cnt    <= '0;
      to_cnt     <= '0;
      s_dqs      <= 1'b0;
      oe         <= 1'b0;
      dq_q       <= '0;
      dm_q       <= '0;
      dqs_q      <= 1'b0;
      wdone      <= 1'b0;
      rvalid     <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      wdone      <= 1'b0;
      rvalid     <= 1'b0;
      rd_timeout <= 1'b0;
      s_dqs      <= DQS_t[0];
      if (abort && state != IDLE) begin
        // cancel: release the bus, keep whatever was captured so far
        state <= IDLE;
        oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid && !abort) begin
              wline_q <= wdata;
              wmask_q <= wmask;
              l_col   <= cmd_col;
              l_bc4   <= cmd_bc4;
              beat    <= '0;
              pre_cnt <= '0;
              to_cnt  <= '0;
              if (cmd_wr) begin
                state <= WPRE;
                oe    <= 1'b1;
                dq_q  <= '0;
                dm_q  <= '1;
                dqs_q <= 1'b0;
              end else begin
                state <= RWAIT;
                s_dqs <= 1'b0;
              end
            end
          end
          WPRE: begin
            if (pre_cnt == PW'(PRE_CYC - 1)) begin
              state <= WDATA;
              dq_q  <= wline_q[beat_idx(l_col, l_bc4, '0)];
              dm_q  <= ~wmask_q[beat_idx(l_col, l_bc4, '0)];
              dqs_q <= 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          WDATA: begin
            if (beat == bl_m1) begin
              state <= WPST;
              dqs_q <= 1'b0;
            end else begin
              beat  <= beat + 1'b1;
              dq_q  <= wline_q[beat_idx(l_col, l_bc4, beat + 1'b1)];
              dm_q  <= ~wmask_q[beat_idx(l_col, l_bc4, beat + 1'b1)];
              dqs_q <= beat[0];
            end
          end
          WPST: begin
            state <= IDLE;
            oe    <= 1'b0;
            wdone <= 1'b1;
          end
          RWAIT, RDATA: begin
            if (dqs_edge) begin
              // an edge on the last timeout cycle still counts
              rline_q[beat_idx(l_col, l_bc4, beat)] <= DQ;
              to_cnt <= '0;
              state  <= RDATA;
              if (beat == bl_m1) begin
                state  <= IDLE;
                rvalid <= 1'b1;
                rword  <= rline_q[beat_idx(l_col, l_bc4, '0)];
              end else begin
                beat <= beat + 1'b1;
              end
            end else if (to_cnt == TW'(RD_TO - 1)) begin
              state      <= IDLE;
              rd_timeout <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            oe    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_burst_xfer.sv
// Directed bench for dram_burst_xfer: write bursts are checked beat by beat
// against a queue of expected pin states, reads against a queue of expected
// completion events built from a bench-side copy of the line register.
module tb_dram_burst_xfer;
  localparam int DQ_W      = 32;
  localparam int BURST_MAX = 8;
  localparam int PRE_CYC   = 1;
  localparam int RD_TO     = 16;
  localparam int DQS_W     = DQ_W / 8;
  localparam int CW        = $clog2(BURST_MAX);

  logic                          CLKx2;
  logic                          nRST;
  logic                          cmd_valid, cmd_wr, cmd_bc4, abort;
  logic [CW-1:0]                 cmd_col;
  logic [BURST_MAX*DQ_W-1:0]     wdata;
  logic [BURST_MAX*DQS_W-1:0]    wmask;
  logic                          cmd_ready, busy, wdone, rvalid, rd_timeout;
  logic [BURST_MAX*DQ_W-1:0]     rdata;
  logic [DQ_W-1:0]               rword;
  wire  [DQ_W-1:0]               DQ;
  wire  [DQS_W-1:0]              DQS_t, DQS_c, DM_n;

  // memory-model side of the bus
  logic                          tb_drv;
  logic                          tb_dqs;
  logic [DQ_W-1:0]               tb_dq;

  assign DQ    = tb_drv ? tb_dq            : {DQ_W{1'bz}};
  assign DQS_t = tb_drv ? {DQS_W{tb_dqs}}  : {DQS_W{1'bz}};
  assign DQS_c = tb_drv ? {DQS_W{~tb_dqs}} : {DQS_W{1'bz}};
  pullup (DQ);
  pullup (DQS_t);
  pullup (DQS_c);
  pullup (DM_n);

  dram_burst_xfer #(.DQ_W(DQ_W), .BURST_MAX(BURST_MAX), .PRE_CYC(PRE_CYC), .RD_TO(RD_TO)) dut (
    .CLKx2(CLKx2), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_bc4(cmd_bc4), .cmd_col(cmd_col), .wdata(wdata), .wmask(wmask),
    .abort(abort), .busy(busy), .wdone(wdone), .rvalid(rvalid), .rd_timeout(rd_timeout),
    .rdata(rdata), .rword(rword), .DQ(DQ), .DQS_t(DQS_t), .DQS_c(DQS_c), .DM_n(DM_n)
  );

  initial CLKx2 = 1'b0;
  always #5 CLKx2 = ~CLKx2;

  typedef struct packed {
    logic             drv;
    logic [DQ_W-1:0]  dq;
    logic [DQS_W-1:0] dm;
    logic             dqs;
    logic             chk_dm;
    logic             wdone;
  } wexp_t;

  typedef struct {
    int                             cyc;
    bit                             full;
    logic [BURST_MAX-1:0][DQ_W-1:0] line;
    logic [DQ_W-1:0]                word;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  int checks   = 0;
  int failures = 0;

  logic [BURST_MAX-1:0][DQ_W-1:0]  wl;
  logic [BURST_MAX-1:0][DQS_W-1:0] wm;
  logic [BURST_MAX-1:0][DQ_W-1:0]  mline;
  logic [DQ_W-1:0]                 mword;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input int col, input bit bc4, input int k);
    if (bc4) return (col / (BURST_MAX / 2)) * (BURST_MAX / 2) + k;
    return (col + k) % BURST_MAX;
  endfunction

  function automatic wexp_t mk(input logic drv, input logic [DQ_W-1:0] dq,
                               input logic [DQS_W-1:0] dm, input logic dqs,
                               input logic chk_dm, input logic wd);
    wexp_t e;
    e.drv = drv; e.dq = dq; e.dm = dm; e.dqs = dqs; e.chk_dm = chk_dm; e.wdone = wd;
    return e;
  endfunction

  task automatic chk_pins(input wexp_t e);
    if (e.drv) begin
      chk("wr_dq", DQ, e.dq);
      chk("wr_dqs_t", DQS_t, {DQS_W{e.dqs}});
      chk("wr_dqs_c", DQS_c, {DQS_W{~e.dqs}});
      if (e.chk_dm) chk("wr_dm_n", DM_n, e.dm);
    end else begin
      chk("rel_dq", DQ, {DQ_W{1'b1}});
      chk("rel_dqs_dm", {DQS_t, DQS_c, DM_n}, {3*DQS_W{1'b1}});
    end
    chk("wr_wdone", wdone, e.wdone);
    chk("wr_busy", busy, e.drv);
  endtask

  // Issue a write from the current negedge; ends on the negedge of the wdone cycle.
  task automatic do_write(input int col, input bit bc4);
    int bl;
    wexp_t e;
    bl = bc4 ? BURST_MAX / 2 : BURST_MAX;
    chk("wr_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_bc4 = bc4; cmd_col = col[CW-1:0];
    wdata = wl; wmask = wm;
    for (int p = 0; p < PRE_CYC; p++) wq.push_back(mk(1'b1, '0, '1, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < bl; k++)
      wq.push_back(mk(1'b1, wl[midx(col, bc4, k)], ~wm[midx(col, bc4, k)], (k % 2) == 0, 1'b1, 1'b0));
    wq.push_back(mk(1'b1, wl[midx(col, bc4, bl - 1)], '0, 1'b0, 1'b0, 1'b0));
    wq.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1));
    @(negedge CLKx2);
    cmd_valid = 1'b0;
    while (wq.size() > 0) begin
      e = wq.pop_front();
      chk_pins(e);
      if (wq.size() > 0) @(negedge CLKx2);
    end
  endtask

  // Issue a read; the model drives nedges DQS edges starting gap cycles after
  // accept with DQ = base+i. Ends on the negedge of the rvalid/timeout cycle.
  task automatic do_read(input int col, input bit bc4, input int nedges, input int gap,
                         input logic [DQ_W-1:0] base);
    int bl, last, e_i;
    rexp_t r;
    bl = bc4 ? BURST_MAX / 2 : BURST_MAX;
    chk("rd_ready", cmd_ready, 1'b1);
    tb_drv = 1'b1; tb_dqs = 1'b0; tb_dq = '0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_bc4 = bc4; cmd_col = col[CW-1:0];
    for (int i = 0; i < nedges; i++) mline[midx(col, bc4, i)] = base + DQ_W'(i);
    r.full = (nedges == bl);
    if (r.full) mword = mline[midx(col, bc4, 0)];
    last   = (nedges > 0) ? gap + nedges : 0;
    r.cyc  = r.full ? gap + bl + 1 : last + RD_TO + 1;
    r.line = mline;
    r.word = mword;
    rq.push_back(r);
    @(negedge CLKx2);
    cmd_valid = 1'b0;
    e_i = 0;
    for (int c = 1; c <= gap + BURST_MAX + RD_TO + 4 && rq.size() > 0; c++) begin
      if (c > gap && e_i < nedges) begin
        tb_dqs = ~tb_dqs;
        tb_dq  = base + DQ_W'(e_i);
        e_i++;
      end
      if (c == rq[0].cyc) begin
        r = rq.pop_front();
        chk("rd_rvalid", rvalid, r.full);
        chk("rd_timeout", rd_timeout, !r.full);
        chk("rd_rdata", rdata, r.line);
        chk("rd_rword", rword, r.word);
        chk("rd_ready_after", cmd_ready, 1'b1);
      end else begin
        chk("rd_quiet", {rvalid, rd_timeout}, 2'b00);
        @(negedge CLKx2);
      end
    end
    chk("rd_event_seen", rq.size(), 0);
    tb_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_bc4 = 1'b0; cmd_col = '0;
    wdata = '0; wmask = '0; abort = 1'b0;
    tb_drv = 1'b0; tb_dqs = 1'b0; tb_dq = '0;
    mline = '0; mword = '0; wm = '0;
    repeat (2) @(negedge CLKx2);
    // reset state
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {wdone, rvalid, rd_timeout}, 3'b000);
    chk("rst_rdata", rdata, '0);
    chk("rst_rword", rword, '0);
    chk("rst_pins", {DQ, DQS_t, DQS_c, DM_n}, {(DQ_W + 3*DQS_W){1'b1}});
    nRST = 1'b1;
    @(negedge CLKx2);

    // BL8 from column 0, no masking
    for (int i = 0; i < BURST_MAX; i++) wl[i] = DQ_W'(32'h1111_1111 * (i + 1));
    wm = '0;
    do_write(0, 1'b0);

    // BL8 wrapping from column 6, byte 1 of the last word masked (back-to-back)
    for (int i = 0; i < BURST_MAX; i++) wl[i] = DQ_W'(32'hC0DE_0000 + i);
    wm = '0;
    wm[BURST_MAX-1][1] = 1'b1;
    do_write(6, 1'b0);

    // BC4 from column 5 stays in the upper half-line
    for (int i = 0; i < BURST_MAX; i++) wl[i] = DQ_W'(32'h5A00_0000 + 32'h0101 * i);
    wm = '0;
    wm[4] = 4'b1000; wm[6] = 4'b0001;
    do_write(5, 1'b1);

    // full BL8 read from column 3
    do_read(3, 1'b0, BURST_MAX, 0, 32'h0000_00A0);
    // no DQS activity: timeout, line unchanged
    do_read(0, 1'b0, 0, 0, 32'h0);
    // three edges then silence: timeout with three words updated
    do_read(2, 1'b0, 3, 0, 32'h0000_00B0);
    // BC4 read whose first edge lands on the last timeout cycle
    do_read(6, 1'b1, BURST_MAX / 2, RD_TO - 1, 32'h0000_00C0);

    // abort together with cmd_valid in IDLE: nothing accepted
    cmd_valid = 1'b1; cmd_wr = 1'b1; abort = 1'b1;
    @(negedge CLKx2);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_pins", {DQ, DQS_t, DQS_c}, {(DQ_W + 2*DQS_W){1'b1}});

    // abort in the middle of a write burst
    for (int i = 0; i < BURST_MAX; i++) wl[i] = DQ_W'(32'hDEAD_0000 + i);
    wm = '0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_bc4 = 1'b0; cmd_col = '0; wdata = wl; wmask = wm;
    @(negedge CLKx2);
    cmd_valid = 1'b0;
    repeat (PRE_CYC + 2) @(negedge CLKx2);
    chk("abort_beat2_dq", DQ, wl[2]);
    abort = 1'b1;
    @(negedge CLKx2);
    abort = 1'b0;
    chk("abort_rel_pins", {DQ, DQS_t, DQS_c, DM_n}, {(DQ_W + 3*DQS_W){1'b1}});
    chk("abort_state", {busy, wdone}, 2'b00);
    @(negedge CLKx2);
    chk("abort_no_wdone", wdone, 1'b0);

    // a following write runs normally
    for (int i = 0; i < BURST_MAX; i++) wl[i] = DQ_W'(32'h7700_0000 + 32'h11 * i);
    wm = '0;
    wm[0] = 4'b0110;
    do_write(1, 1'b1);

    // reset in the middle of a read
    tb_drv = 1'b1; tb_dqs = 1'b0; tb_dq = 32'h0000_00E0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_bc4 = 1'b0; cmd_col = CW'(1);
    @(negedge CLKx2);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tb_dqs = ~tb_dqs;
      tb_dq  = DQ_W'(32'hE0 + i);
      @(negedge CLKx2);
    end
    chk("midrd_busy", busy, 1'b1);
    #2 nRST = 1'b0;
    #1;
    mline = '0; mword = '0;
    chk("midrd_rst_ready", {cmd_ready, busy}, 2'b10);
    chk("midrd_rst_pulses", {wdone, rvalid, rd_timeout}, 3'b000);
    chk("midrd_rst_rdata", rdata, '0);
    chk("midrd_rst_rword", rword, '0);
    tb_drv = 1'b0;
    #1;
    chk("midrd_rst_pins", {DQ, DQS_t, DQS_c, DM_n}, {(DQ_W + 3*DQS_W){1'b1}});
    @(negedge CLKx2);
    nRST = 1'b1;
    @(negedge CLKx2);

    // recovery after reset: full read wrapping from column 7
    do_read(7, 1'b0, BURST_MAX, 0, 32'h0000_0F00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
